// File: rtl/spi_tx_if.sv
// Word handshake and SPI pin bundle for spi_tx.
// The slave modport is the transmitter's view.
interface spi_tx_if #(
   parameter int WIDTH = 10
);
   logic [WIDTH-1:0] Data_in;
   logic Data_valid;
   logic Ready;
   logic Done;
   logic SPI_clk;
   logic SPI_Data_out;
   logic CS;

   modport master (
      output Data_in,
      output Data_valid,
      input  Ready,
      input  Done,
      input  SPI_clk,
      input  SPI_Data_out,
      input  CS
   );

   modport slave (
      input  Data_in,
      input  Data_valid,
      output Ready,
      output Done,
      output SPI_clk,
      output SPI_Data_out,
      output CS
   );
endinterface

// File: rtl/spi_tx.sv
// SPI mode-0 master transmitter, MSB first.
// Payload is followed by zero pad bits up to TOTAL_BITS.
module spi_tx #(
   parameter int WIDTH      = 10,
   parameter int TOTAL_BITS = 14,
   parameter int CLK_HALF   = 2
) (
   input logic     clk,
   input logic     reset,
   spi_tx_if.slave bus
);

   localparam int HW  = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
   localparam int BW  = $clog2(TOTAL_BITS + 1);
   localparam int PAD = TOTAL_BITS - WIDTH;
   localparam logic [HW-1:0] HMAX = HW'(CLK_HALF - 1);
   localparam logic [BW-1:0] BMAX = BW'(TOTAL_BITS);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   state_t state, state_nxt;

   logic [HW-1:0] hcnt, hcnt_nxt;
   logic [BW-1:0] bcnt, bcnt_nxt;

   logic [TOTAL_BITS-1:0] sr, sr_nxt;
   logic [TOTAL_BITS-1:0] sr_load;
   logic [TOTAL_BITS-1:0] sr_shl;

   logic ready_q, ready_nxt;
   logic done_q, done_nxt;
   logic sclk_q, sclk_nxt;
   logic mosi_q, mosi_nxt;
   logic cs_q, cs_nxt;
   logic tick;

   assign tick    = (hcnt == HMAX);
   assign sr_load = TOTAL_BITS'(bus.Data_in) << PAD;
   assign sr_shl  = sr << 1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         hcnt    <= '0;
         bcnt    <= '0;
         sr      <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         cs_q    <= 1'b1;
      end else begin
         state   <= state_nxt;
         hcnt    <= hcnt_nxt;
         bcnt    <= bcnt_nxt;
         sr      <= sr_nxt;
         ready_q <= ready_nxt;
         done_q  <= done_nxt;
         sclk_q  <= sclk_nxt;
         mosi_q  <= mosi_nxt;
         cs_q    <= cs_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      hcnt_nxt  = tick ? '0 : hcnt + HW'(1);
      bcnt_nxt  = bcnt;
      sr_nxt    = sr;
      ready_nxt = ready_q;
      done_nxt  = 1'b0;
      sclk_nxt  = sclk_q;
      mosi_nxt  = mosi_q;
      cs_nxt    = cs_q;

      unique case (state)
         IDLE: begin
            hcnt_nxt = '0;
            if (bus.Data_valid) begin
               state_nxt = SETUP;
               sr_nxt    = sr_load;
               mosi_nxt  = sr_load[TOTAL_BITS-1];
               cs_nxt    = 1'b0;
               ready_nxt = 1'b0;
               bcnt_nxt  = '0;
            end
         end
         SETUP: begin
            if (tick) begin
               state_nxt = SHIFT;
               sclk_nxt  = 1'b1;
               bcnt_nxt  = bcnt + BW'(1);
            end
         end
         SHIFT: begin
            if (tick) begin
               if (!sclk_q) begin
                  sclk_nxt = 1'b1;
                  bcnt_nxt = bcnt + BW'(1);
               end else if (bcnt == BMAX) begin
                  // last fall: park MOSI, keep the register
                  sclk_nxt  = 1'b0;
                  mosi_nxt  = 1'b0;
                  state_nxt = HOLD;
               end else begin
                  sclk_nxt = 1'b0;
                  sr_nxt   = sr_shl;
                  mosi_nxt = sr_shl[TOTAL_BITS-1];
               end
            end
         end
         HOLD: begin
            if (tick) begin
               cs_nxt    = 1'b1;
               done_nxt  = 1'b1;
               state_nxt = GAP;
            end
         end
         GAP: begin
            if (tick) begin
               ready_nxt = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.Ready        = ready_q;
   assign bus.Done         = done_q;
   assign bus.SPI_clk      = sclk_q;
   assign bus.SPI_Data_out = mosi_q;
   assign bus.CS           = cs_q;

endmodule

// File: tb/tb_spi_tx.sv
// Randomised bench for spi_tx with a frame-level slave model.
// A second instance covers the WIDTH=TOTAL_BITS, CLK_HALF=1 corner.
module tb_spi_tx;

   localparam int W      = 10;
   localparam int TB     = 14;
   localparam int CH     = 2;
   localparam int PAD    = TB - W;
   localparam int CS_LOW = (2 * TB + 1) * CH;
   localparam int RDY_AT = (2 * TB + 2) * CH;
   localparam int PERIOD = RDY_AT + 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_tx_if #(.WIDTH(W)) a_if ();
   spi_tx_if #(.WIDTH(8)) b_if ();

   spi_tx #(
      .WIDTH(W),
      .TOTAL_BITS(TB),
      .CLK_HALF(CH)
   ) dut_a (
      .clk(clk),
      .reset(reset),
      .bus(a_if)
   );

   spi_tx #(
      .WIDTH(8),
      .TOTAL_BITS(8),
      .CLK_HALF(1)
   ) dut_b (
      .clk(clk),
      .reset(reset),
      .bus(b_if)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag,
                        input longint got,
                        input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   logic [W-1:0] exp_q[$];

   logic p_clk, p_mosi, p_cs, p_rdy;
   bit   in_frame = 0;
   int   f_start, f_rises, f_done, f_cs_hi, f_rdy, f_errs, f_dn;
   logic [TB-1:0] f_cap;
   int   acc_cnt = 0, acc_prev = 0, acc_last = 0;
   int   done_total = 0;
   int   cs_rise_at = -1000;

   task automatic finish_frame();
      logic [W-1:0]  w;
      logic [TB-1:0] e;
      if (exp_q.size() == 0) begin
         check("exp_empty", 1, 0);
         return;
      end
      w = exp_q.pop_front();
      e = TB'(w) << PAD;
      check("frame", f_cap, e);
      check("rises", f_rises, TB);
      check("cs_low", f_cs_hi, CS_LOW);
      check("done_at", f_done, CS_LOW);
      check("n_done", f_dn, 1);
      check("ready_at", f_rdy, RDY_AT);
      check("mosi_rule", f_errs, 0);
   endtask

   always @(negedge clk) begin
      logic [W-1:0] hd;
      if (reset) begin
         in_frame = 0;
      end else begin
         if (a_if.Data_valid && p_rdy) begin
            acc_cnt++;
            acc_prev = acc_last;
            acc_last = cyc;
            check("cs_gap", (cyc - cs_rise_at) >= CH, 1);
            check("cs_fall", a_if.CS, 0);
            if (exp_q.size() != 0) begin
               hd = exp_q[0];
               check("msb", a_if.SPI_Data_out, hd[W-1]);
            end else begin
               check("spurious", 1, 0);
            end
            in_frame = 1;
            f_start = cyc;
            f_rises = 0;
            f_cap = '0;
            f_done = -1;
            f_cs_hi = -1;
            f_rdy = -1;
            f_errs = 0;
            f_dn = 0;
         end
         if (in_frame) begin
            if (a_if.SPI_clk && !p_clk) begin
               f_rises++;
               f_cap = {f_cap[TB-2:0], a_if.SPI_Data_out};
               if (cyc - f_start != (2 * f_rises - 1) * CH) f_errs++;
            end
            if (a_if.SPI_Data_out != p_mosi && a_if.SPI_clk) f_errs++;
            if (a_if.Done) begin
               f_dn++;
               if (f_done < 0) f_done = cyc - f_start;
            end
            if (a_if.CS && !p_cs) f_cs_hi = cyc - f_start;
            if (a_if.Ready && !p_rdy) begin
               f_rdy = cyc - f_start;
               if (a_if.SPI_Data_out != 1'b0) f_errs++;
               finish_frame();
               in_frame = 0;
            end
         end
         if (a_if.CS && !p_cs) cs_rise_at = cyc;
         if (a_if.Done) done_total++;
      end
      p_clk  = a_if.SPI_clk;
      p_mosi = a_if.SPI_Data_out;
      p_cs   = a_if.CS;
      p_rdy  = a_if.Ready;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((in_frame || !a_if.Ready) && n < budget) begin
         tick();
         n++;
      end
      check("idle_wait", n < budget, 1);
   endtask

   task automatic wait_acc(input int target, input int budget);
      int n = 0;
      while (acc_cnt < target && n < budget) begin
         tick();
         n++;
      end
      check("acc_wait", n < budget, 1);
   endtask

   task automatic send(input logic [W-1:0] w, input int hold);
      exp_q.push_back(w);
      a_if.Data_in = w;
      a_if.Data_valid = 1'b1;
      repeat (hold) tick();
      a_if.Data_valid = 1'b0;
   endtask

   task automatic run_b(input logic [7:0] w);
      logic [7:0] cap = '0;
      int rises = 0, dat = -1, rat = -1, errs = 0;
      int st, rel;
      logic pc = 1'b0, pr = 1'b0;
      check("b_idle", b_if.Ready, 1);
      b_if.Data_in = w;
      b_if.Data_valid = 1'b1;
      @(posedge clk);
      #1;
      b_if.Data_valid = 1'b0;
      st = cyc;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         rel = cyc - st;
         if (b_if.SPI_clk && !pc) begin
            rises++;
            cap = {cap[6:0], b_if.SPI_Data_out};
         end
         if (rel >= 1 && rel <= 16 && b_if.SPI_clk != (rel % 2 == 1)) errs++;
         if (b_if.Done && dat < 0) dat = rel;
         if (b_if.Ready && !pr && rat < 0) rat = rel;
         pc = b_if.SPI_clk;
         pr = b_if.Ready;
      end
      check("b_frame", cap, w);
      check("b_rises", rises, 8);
      check("b_clk_div2", errs, 0);
      check("b_done_at", dat, 17);
      check("b_ready_at", rat, 18);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, a0, t;
      logic [W-1:0] w;
      a_if.Data_valid = 1'b0;
      a_if.Data_in = '0;
      b_if.Data_valid = 1'b0;
      b_if.Data_in = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_a", {a_if.Ready, a_if.CS, a_if.SPI_clk,
                      a_if.SPI_Data_out, a_if.Done}, 5'b11000);
      check("rst_b", {b_if.Ready, b_if.CS, b_if.SPI_clk,
                      b_if.SPI_Data_out, b_if.Done}, 5'b11000);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle", {a_if.Ready, a_if.CS, a_if.SPI_clk,
                        a_if.SPI_Data_out, a_if.Done}, 5'b11000);
      end

      send(10'h2A5, 1);
      wait_idle(200);

      a0 = acc_cnt;
      exp_q.push_back(10'h3FF);
      exp_q.push_back(10'h001);
      a_if.Data_in = 10'h3FF;
      a_if.Data_valid = 1'b1;
      wait_acc(a0 + 1, 10);
      a_if.Data_in = 10'h001;
      wait_acc(a0 + 2, 200);
      a_if.Data_valid = 1'b0;
      check("b2b_period", acc_last - acc_prev, PERIOD);
      wait_idle(200);

      d0 = done_total;
      send(10'h0F0, 1);
      repeat (19) tick();
      a_if.Data_in = 10'h155;
      a_if.Data_valid = 1'b1;
      tick();
      a_if.Data_valid = 1'b0;
      wait_idle(200);
      check("busy_dones", done_total - d0, 1);
      check("busy_q", exp_q.size(), 0);

      d0 = done_total;
      send(10'h2C7, 1);
      repeat (29) tick();
      reset = 1'b1;
      #1;
      check("mid_rst", {a_if.Ready, a_if.CS, a_if.SPI_clk,
                        a_if.SPI_Data_out, a_if.Done}, 5'b11000);
      exp_q.delete();
      tick();
      tick();
      reset = 1'b0;
      repeat (70) tick();
      check("rst_no_done", done_total - d0, 0);
      send(10'h3C3, 1);
      wait_idle(200);

      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 4)) tick();
         w = W'($urandom);
         send(w, $urandom_range(1, 3));
         if ($urandom_range(0, 1) == 1) begin
            t = $urandom_range(5, 50);
            repeat (t) tick();
            a_if.Data_in = W'($urandom);
            a_if.Data_valid = 1'b1;
            tick();
            a_if.Data_valid = 1'b0;
         end
         wait_idle(200);
      end
      check("final_q", exp_q.size(), 0);

      run_b(8'h81);
      run_b(8'($urandom));
      run_b(8'($urandom));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
